// File: rtl/bmem_pkg.sv
// bmem_pkg: types and constants shared by every block on the burst-memory (bmem) bus.
//   BMEM_BEATS        beats per cache line
//   BMEM_BEAT_W       bits per beat
//   BMEM_LINE_BYTES   bytes per cache line
//   bmem_wstate_t     write-burst FSM states
//   bmem_rstate_t     read-response FSM states
//   bmem_rdq_entry_t  outstanding read: line address plus acceptance timestamp
package bmem_pkg;

  localparam int unsigned BMEM_BEATS      = 4;
  localparam int unsigned BMEM_BEAT_W     = 64;
  localparam int unsigned BMEM_LINE_BYTES = 32;

  typedef enum logic {
    W_IDLE,
    W_BURST
  } bmem_wstate_t;

  typedef enum logic {
    R_IDLE,
    R_BEAT
  } bmem_rstate_t;

  typedef struct packed {
    logic [31:5] addr;
    logic [7:0]  stamp;
  } bmem_rdq_entry_t;

endpackage

// File: rtl/bmem_responder_if.sv
// bmem_responder_if: the bmem bus between a core (master) and a memory responder (slave).
//   bmem_addr    master->slave  byte address, bits [4:0] ignored
//   bmem_read    master->slave  one-cycle read command for a whole line
//   bmem_write   master->slave  write beat valid, four consecutive cycles per line
//   bmem_wdata   master->slave  write beat data, beat 0 first
//   bmem_ready   slave->master  a new command (read or first write beat) is taken this cycle
//   bmem_raddr   slave->master  line address of the current response beat
//   bmem_rdata   slave->master  response beat data
//   bmem_rvalid  slave->master  response beat valid, never stalled
interface bmem_responder_if;
  import bmem_pkg::*;

  logic [31:0]            bmem_addr;
  logic                   bmem_read;
  logic                   bmem_write;
  logic [BMEM_BEAT_W-1:0] bmem_wdata;
  logic                   bmem_ready;
  logic [31:0]            bmem_raddr;
  logic [BMEM_BEAT_W-1:0] bmem_rdata;
  logic                   bmem_rvalid;

  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid
  );

endinterface

// File: rtl/bmem_rdq.sv
// bmem_rdq: FIFO of outstanding read commands, each stamped with its acceptance cycle.
//   clk, rst     clock, synchronous active-high reset (empties the queue)
//   push         enqueue push_entry (caller guarantees count < DEPTH)
//   push_entry   entry to enqueue
//   pop          drop the head (caller guarantees count > 0)
//   count        number of entries held
//   head         oldest entry
//   head_next    entry behind the head, valid when count >= 2; lets the responder
//                chain back-to-back lines without a bubble
module bmem_rdq
  import bmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  bmem_rdq_entry_t          push_entry,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output bmem_rdq_entry_t          head,
  output bmem_rdq_entry_t          head_next
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  bmem_rdq_entry_t entries [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;

  // Payload storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign count     = count_q;
  assign head      = entries[rd_ptr_q];
  assign head_next = entries[rd_ptr_q + PW'(1)];

endmodule

// File: rtl/bmem_responder.sv
// bmem_responder: on-chip memory at the slave end of the bmem bus.
//   clk        clock
//   rst        synchronous active-high reset; storage contents survive it
//   bus        bmem_responder_if.slave (commands in, response beats out)
//   proto_err  sticky protocol-violation flag, present only when BMEM_RESP_PROTCHK_EN
//              is defined
// Parameters:
//   MEM_WORDS_LG2  log2 of storage depth in 64-bit words; upper address bits alias
//   LATENCY        read accept to first beat, in cycles (1..255; 1 behaves as 2)
//   RDQ_DEPTH      outstanding reads held, power of two, >= 2
// Optional build macro: BMEM_RESP_PROTCHK_EN.
module bmem_responder
  import bmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS_LG2 = 12,
  parameter int unsigned LATENCY       = 8,
  parameter int unsigned RDQ_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst,
  bmem_responder_if.slave    bus
`ifdef BMEM_RESP_PROTCHK_EN
  ,
  output logic               proto_err
`endif
);

  localparam int unsigned MEM_DEPTH = 1 << MEM_WORDS_LG2;
  localparam int unsigned LINE_W    = MEM_WORDS_LG2 - 2;
  localparam int unsigned CW        = $clog2(RDQ_DEPTH) + 1;
  // Output beats are registered, so the head is launched one cycle before it is due.
  localparam logic [7:0]  ELIG_AGE  = 8'(LATENCY - 1);

  logic [BMEM_BEAT_W-1:0] mem [MEM_DEPTH];

  bmem_wstate_t           wstate_q, wstate_d;
  logic [1:0]             wbeat_q, wbeat_d;
  logic [LINE_W-1:0]      wline_q, wline_d;
  bmem_rstate_t           rstate_q, rstate_d;
  logic [1:0]             rbeat_q, rbeat_d;
  logic [7:0]             cyc_q;
  logic                   ready_q, ready_d;
  logic                   rvalid_q;
  logic [31:0]            raddr_q;
  logic [BMEM_BEAT_W-1:0] rdata_q;

  logic                   mem_we;
  logic [MEM_WORDS_LG2-1:0] mem_widx, mem_ridx;
  logic [LINE_W-1:0]      addr_line;
  logic                   wr_accept, rd_accept;

  logic                   load, pop;
  logic [31:5]            load_addr;
  logic [1:0]             load_beat;
  logic [7:0]             head_age, next_age;
  logic                   head_ok, next_ok;

  logic [CW-1:0]          rdq_count, count_d;
  bmem_rdq_entry_t        rdq_head, rdq_head_next, rdq_push_entry;

  logic                   unused_addr;
  assign unused_addr = ^bus.bmem_addr[4:0];

  assign addr_line = bus.bmem_addr[5 +: LINE_W];
  // ready_q already implies W_IDLE and a free queue slot in this cycle.
  assign wr_accept = bus.bmem_write && ready_q;
  assign rd_accept = bus.bmem_read && ready_q && !bus.bmem_write;

  assign rdq_push_entry = '{addr: bus.bmem_addr[31:5], stamp: cyc_q};

  bmem_rdq #(
    .DEPTH (RDQ_DEPTH)
  ) u_rdq (
    .clk        (clk),
    .rst        (rst),
    .push       (rd_accept),
    .push_entry (rdq_push_entry),
    .pop        (pop),
    .count      (rdq_count),
    .head       (rdq_head),
    .head_next  (rdq_head_next)
  );

  // Write burst FSM. Beats after the first are consumed unconditionally.
  always_comb begin
    wstate_d = wstate_q;
    wbeat_d  = wbeat_q;
    wline_d  = wline_q;
    mem_we   = 1'b0;
    mem_widx = {wline_q, wbeat_q};
    unique case (wstate_q)
      W_IDLE: begin
        if (wr_accept) begin
          mem_we   = 1'b1;
          mem_widx = {addr_line, 2'd0};
          wline_d  = addr_line;
          wbeat_d  = 2'd1;
          wstate_d = W_BURST;
        end
      end
      W_BURST: begin
        mem_we  = 1'b1;
        wbeat_d = wbeat_q + 2'd1;
        if (wbeat_q == 2'd3) wstate_d = W_IDLE;
      end
    endcase
  end

  // Modulo-256 ages tolerate cyc_q wrapping.
  assign head_age = cyc_q - rdq_head.stamp;
  assign next_age = cyc_q - rdq_head_next.stamp;
  assign head_ok  = (rdq_count != '0) && (head_age >= ELIG_AGE);
  assign next_ok  = (rdq_count >= CW'(2)) && (next_age >= ELIG_AGE);

  // Response FSM: rstate_q/rbeat_q describe the beat currently on the bus; "load"
  // fetches the beat that will be on the bus next cycle.
  always_comb begin
    rstate_d  = rstate_q;
    rbeat_d   = rbeat_q;
    load      = 1'b0;
    pop       = 1'b0;
    load_addr = rdq_head.addr;
    load_beat = 2'd0;
    unique case (rstate_q)
      R_IDLE: begin
        if (head_ok) begin
          load     = 1'b1;
          rstate_d = R_BEAT;
          rbeat_d  = 2'd0;
        end
      end
      R_BEAT: begin
        if (rbeat_q != 2'd3) begin
          load      = 1'b1;
          load_beat = rbeat_q + 2'd1;
          rbeat_d   = rbeat_q + 2'd1;
        end else begin
          pop = 1'b1;
          if (next_ok) begin
            load      = 1'b1;
            load_addr = rdq_head_next.addr;
            rbeat_d   = 2'd0;
          end else begin
            rstate_d = R_IDLE;
          end
        end
      end
    endcase
  end

  assign mem_ridx = {load_addr[5 +: LINE_W], load_beat};
  assign count_d  = rdq_count + CW'(rd_accept) - CW'(pop);
  assign ready_d  = (wstate_d == W_IDLE) && (count_d < CW'(RDQ_DEPTH));

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_widx] <= bus.bmem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q <= W_IDLE;
      wbeat_q  <= 2'd0;
      wline_q  <= '0;
      rstate_q <= R_IDLE;
      rbeat_q  <= 2'd0;
      cyc_q    <= 8'd0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wstate_q <= wstate_d;
      wbeat_q  <= wbeat_d;
      wline_q  <= wline_d;
      rstate_q <= rstate_d;
      rbeat_q  <= rbeat_d;
      cyc_q    <= cyc_q + 8'd1;
      ready_q  <= ready_d;
      rvalid_q <= load;
      if (load) begin
        // Read at launch time: a same-cycle write to this word yields the old data.
        raddr_q <= {load_addr, 5'd0};
        rdata_q <= mem[mem_ridx];
      end
    end
  end

  assign bus.bmem_ready  = ready_q;
  assign bus.bmem_rvalid = rvalid_q;
  assign bus.bmem_raddr  = raddr_q;
  assign bus.bmem_rdata  = rdata_q;

`ifdef BMEM_RESP_PROTCHK_EN
  logic proto_viol;
  logic proto_err_q;

  assign proto_viol = (wstate_q == W_BURST && !bus.bmem_write) ||
                      (wstate_q != W_BURST && !ready_q && (bus.bmem_read || bus.bmem_write)) ||
                      (bus.bmem_read && bus.bmem_write);

  always_ff @(posedge clk) begin
    if (rst) begin
      proto_err_q <= 1'b0;
    end else if (proto_viol) begin
      proto_err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && proto_viol) begin
      $error("bmem protocol violation, addr %h", bus.bmem_addr);
    end
  end
`endif

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_bmem_responder.sv
module tb_bmem_responder;
  localparam int LAT = 8;

  logic clk;
  logic rst;
  bmem_responder_if bus ();
`ifdef BMEM_RESP_PROTCHK_EN
  logic proto_err;
`endif

  bmem_responder #(
    .MEM_WORDS_LG2 (12),
    .LATENCY       (LAT),
    .RDQ_DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus)
`ifdef BMEM_RESP_PROTCHK_EN
    ,
    .proto_err (proto_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tb_cyc = 0;
  always @(posedge clk) tb_cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // ---------------- Reference model ----------------
  // Line k of a read accepted at cycle a starts its 4 beats at
  // max(a + LAT, previous line start + 4); a slot frees after the line's last beat.
  typedef struct {
    logic [26:0] line;
    int          s;
  } rsp_t;

  rsp_t        mq[$];
  logic [63:0] mm[int];
  int          last_s = -1000;
  int          m_burst = 0;
  logic [9:0]  m_wline;
  bit          m_rst_prev = 1'b1;
  bit          pend_v = 1'b0;
  int          pend_idx;
  logic [63:0] pend_d;
  int          y, beat, idx, s_new;
  bit          exp_ready, exp_rv;

  function automatic int widx(input logic [9:0] line, input int b);
    return int'(line) * 4 + b;
  endfunction

  always @(negedge clk) begin
    y = tb_cyc;
    while (mq.size() > 0 && mq[0].s + 3 < y) void'(mq.pop_front());
    exp_ready = !m_rst_prev && m_burst == 0 && mq.size() < 4;
    chk("ready", 64'(bus.bmem_ready), 64'(exp_ready));
    exp_rv = mq.size() > 0 && mq[0].s <= y;
    chk("rvalid", 64'(bus.bmem_rvalid), 64'(exp_rv));
    if (exp_rv) begin
      beat = y - mq[0].s;
      idx  = widx(mq[0].line[9:0], beat);
      chk("raddr", 64'(bus.bmem_raddr), 64'({mq[0].line, 5'd0}));
      if (mm.exists(idx)) chk("rdata", bus.bmem_rdata, mm[idx]);
    end
    // Writes land at the end of their cycle, so they become visible two cycles on.
    if (pend_v) mm[pend_idx] = pend_d;
    pend_v = 1'b0;
    if (rst) begin
      mq.delete();
      m_burst    = 0;
      m_rst_prev = 1'b1;
      last_s     = -1000;
    end else begin
      m_rst_prev = 1'b0;
      if (m_burst > 0) begin
        pend_v   = 1'b1;
        pend_idx = widx(m_wline, 4 - m_burst);
        pend_d   = bus.bmem_wdata;
        m_burst--;
      end else if (exp_ready && bus.bmem_write) begin
        m_wline  = bus.bmem_addr[14:5];
        pend_v   = 1'b1;
        pend_idx = widx(m_wline, 0);
        pend_d   = bus.bmem_wdata;
        m_burst  = 3;
      end else if (exp_ready && bus.bmem_read) begin
        s_new = (y + LAT > last_s + 4) ? y + LAT : last_s + 4;
        mq.push_back('{line: bus.bmem_addr[31:5], s: s_new});
        last_s = s_new;
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 64; i++) begin
      if (bus.bmem_ready) return;
      step();
    end
    chk("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic wr_line(input logic [31:0] a, input logic [255:0] d, input bit with_rd);
    wait_ready();
    bus.bmem_addr  = a;
    bus.bmem_write = 1'b1;
    bus.bmem_read  = with_rd;
    for (int b = 0; b < 4; b++) begin
      bus.bmem_wdata = d[64*b +: 64];
      step();
      bus.bmem_read = 1'b0;
    end
    bus.bmem_write = 1'b0;
  endtask

  task automatic rd_line(input logic [31:0] a, output int acc);
    wait_ready();
    bus.bmem_addr = a;
    bus.bmem_read = 1'b1;
    acc = tb_cyc;
    step();
    bus.bmem_read = 1'b0;
  endtask

  task automatic wait_rv(output int rc);
    rc = -1;
    for (int i = 0; i < 64; i++) begin
      if (bus.bmem_rvalid) begin
        rc = tb_cyc;
        return;
      end
      step();
    end
    chk("rvalid_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    logic [255:0] r;
    for (int b = 0; b < 4; b++) r[64*b +: 64] = {32'hC0DE_0000 | 32'(b), a};
    return r;
  endfunction

  int          acc, rc;
  int          accs[5];
  logic [255:0] l1000, lalias_y, lalias_x;

  initial begin
    l1000    = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    lalias_x = {64'hDEAD_0000_0000_0003, 64'hDEAD_0000_0000_0002,
                64'hDEAD_0000_0000_0001, 64'hDEAD_0000_0000_0000};
    lalias_y = {64'h8000_0000_0000_0003, 64'h8000_0000_0000_0002,
                64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000};
    rst = 1'b1;
    bus.bmem_addr  = '0;
    bus.bmem_read  = 1'b0;
    bus.bmem_write = 1'b0;
    bus.bmem_wdata = '0;

    // Reset
    step();
    chk("rst_ready", 64'(bus.bmem_ready), 64'd0);
    chk("rst_rvalid", 64'(bus.bmem_rvalid), 64'd0);
    chk("rst_rdata", bus.bmem_rdata, 64'd0);
    chk("rst_raddr", 64'(bus.bmem_raddr), 64'd0);
    step();
    rst = 1'b0;
    step();
    chk("ready_after_rst", 64'(bus.bmem_ready), 64'd1);

    // Write then read one line
    wr_line(32'h1000, l1000, 1'b0);
    rd_line(32'h1000, acc);
    wait_rv(rc);
    chk("rd_latency", 64'(rc - acc), 64'(LAT));
    for (int b = 0; b < 4; b++) begin
      chk("t1_raddr", 64'(bus.bmem_raddr), 64'h1000);
      chk("t1_rdata", bus.bmem_rdata, l1000[64*b +: 64]);
      step();
    end
    chk("t1_done", 64'(bus.bmem_rvalid), 64'd0);

    // Five back-to-back reads into a 4-deep queue
    wr_line(32'h1020, pat(32'h1020), 1'b0);
    wr_line(32'h1040, pat(32'h1040), 1'b0);
    wr_line(32'h1060, pat(32'h1060), 1'b0);
    rd_line(32'h1000, accs[0]);
    rd_line(32'h1020, accs[1]);
    rd_line(32'h1040, accs[2]);
    rd_line(32'h1060, accs[3]);
    chk("full_ready", 64'(bus.bmem_ready), 64'd0);
    rd_line(32'h1000, accs[4]);
    chk("acc4_back2back", 64'(accs[3] - accs[0]), 64'd3);
    chk("acc5_after_pop", 64'(accs[4] - accs[0]), 64'd12);
    idle(40);

    // Read and write together: write wins
    wr_line(32'h2000, pat(32'h2000), 1'b1);
    idle(20);
`ifdef BMEM_RESP_PROTCHK_EN
    chk("proto_err", 64'(proto_err), 64'd1);
`endif
    rd_line(32'h2000, acc);
    wait_rv(rc);
    chk("t3_beat0", bus.bmem_rdata, 64'hC0DE_0000_0000_2000);
    idle(10);

    // Address alias across bit 15
    wr_line(32'h0, lalias_x, 1'b0);
    wr_line(32'h8000, lalias_y, 1'b0);
    rd_line(32'h0, acc);
    wait_rv(rc);
    chk("alias_raddr", 64'(bus.bmem_raddr), 64'h0);
    chk("alias_beat0", bus.bmem_rdata, 64'h8000_0000_0000_0000);
    idle(10);

    // Reset in the middle of a response
    rd_line(32'h8000, acc);
    wait_rv(rc);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_mid_rvalid", 64'(bus.bmem_rvalid), 64'd0);
    rst = 1'b0;
    idle(20);
    rd_line(32'h8000, acc);
    wait_rv(rc);
    chk("after_rst_beat0", bus.bmem_rdata, 64'h8000_0000_0000_0000);
    step();
    chk("after_rst_beat1", bus.bmem_rdata, 64'h8000_0000_0000_0001);
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", tb_cyc);
    $fatal(1);
  end

endmodule
